// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative 32x32 multiply / restoring divide unit writing HI/LO
// Signed MULT/DIV on op[1] is built only when MULDIV_SIGNED_EN is defined.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dato_A,
    input  logic [31:0] dato_B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic        is_div_r;
    logic [31:0] a_raw_r;
    logic [31:0] opd_r;
    logic [31:0] acc_hi, acc_lo;

    logic        accept;
    logic        last_step;
    logic        zero_div;
    logic [31:0] mag_a, mag_b;

    assign accept    = (state != RUN) && start;
    assign last_step = (cnt == 5'd31);
    assign zero_div  = is_div_r && (opd_r == 32'd0);
    assign busy      = (state == RUN);
    assign done      = (state == FINISH);

`ifdef MULDIV_SIGNED_EN
    logic a_neg_in, b_neg_in;
    logic neg_q_r, neg_r_r;

    assign a_neg_in = op[1] & dato_A[31];
    assign b_neg_in = op[1] & dato_B[31];
    assign mag_a    = a_neg_in ? (~dato_A + 32'd1) : dato_A;
    assign mag_b    = b_neg_in ? (~dato_B + 32'd1) : dato_B;

    // Remainder follows the dividend sign; only meaningful for divides.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept) begin
            neg_q_r <= a_neg_in ^ b_neg_in;
            neg_r_r <= op[0] & a_neg_in;
        end
    end
`else
    logic unused_op_sign;
    assign unused_op_sign = op[1];
    assign mag_a = dato_A;
    assign mag_b = dato_B;
`endif

    // acc_hi:acc_lo holds partial product / multiplier, or remainder / dividend-quotient.
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] step_hi, step_lo;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd_r} : 33'd0);
        div_sh   = {acc_hi, acc_lo[31]};
        div_diff = div_sh - {1'b0, opd_r};
        div_ge   = (div_sh >= {1'b0, opd_r});
        if (is_div_r) begin
            step_hi = div_ge ? div_diff[31:0] : div_sh[31:0];
            step_lo = {acc_lo[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo[31:1]};
        end
    end

    logic [31:0] fin_hi, fin_lo;

`ifdef MULDIV_SIGNED_EN
    logic [63:0] prod_neg;

    always_comb begin
        prod_neg = ~{step_hi, step_lo} + 64'd1;
        fin_hi   = step_hi;
        fin_lo   = step_lo;
        if (is_div_r) begin
            if (neg_q_r) fin_lo = ~step_lo + 32'd1;
            if (neg_r_r) fin_hi = ~step_hi + 32'd1;
        end else if (neg_q_r) begin
            fin_hi = prod_neg[63:32];
            fin_lo = prod_neg[31:0];
        end
    end
`else
    assign fin_hi = step_hi;
    assign fin_lo = step_lo;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (zero_div || last_step) state_next = FINISH;
            FINISH:  state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 5'd0;
            is_div_r    <= 1'b0;
            a_raw_r     <= 32'd0;
            opd_r       <= 32'd0;
            acc_hi      <= 32'd0;
            acc_lo      <= 32'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= 5'd0;
            is_div_r <= op[0];
            a_raw_r  <= dato_A;
            opd_r    <= op[0] ? mag_b : mag_a;
            acc_hi   <= 32'd0;
            acc_lo   <= op[0] ? mag_a : mag_b;
        end else if (state == RUN) begin
            if (zero_div) begin
                hi          <= a_raw_r;
                lo          <= 32'hFFFF_FFFF;
                div_by_zero <= 1'b1;
            end else begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + 5'd1;
                if (last_step) begin
                    hi          <= fin_hi;
                    lo          <= fin_lo;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - table-driven self-checking bench for ex_muldiv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  op;
    logic [31:0] dato_A, dato_B;
    logic [31:0] hi, lo;
    logic        busy, done, div_by_zero;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dato_A(dato_A), .dato_B(dato_B),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        op = v.op; dato_A = v.a; dato_B = v.b; start = 1'b1;
        tick;
        chk($sformatf("v%0d_busy_start", idx), {31'd0, busy}, 32'd1);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (n == 3) begin
                start = 1'b1; op = ~v.op; dato_A = ~v.a; dato_B = 32'd5;
            end
            if (n == 5) start = 1'b0;
            if (n == 16) begin
                chk($sformatf("v%0d_hi_hold", idx), hi, prev_hi);
                chk($sformatf("v%0d_lo_hold", idx), lo, prev_lo);
            end
            tick;
            n++;
        end
        start = 1'b0;
        chk($sformatf("v%0d_latency", idx), n, v.exp_lat);
        chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_hi", idx), hi, v.exp_hi);
        chk($sformatf("v%0d_lo", idx), lo, v.exp_lo);
        chk($sformatf("v%0d_dz", idx), {31'd0, div_by_zero}, {31'd0, v.exp_dz});
        tick;
        chk($sformatf("v%0d_done_fall", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_busy_idle", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d_hi_keep", idx), hi, v.exp_hi);
        prev_hi = v.exp_hi;
        prev_lo = v.exp_lo;
    endtask

    initial begin
        int n;
        logic seen;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32};
        vecs[1]  = '{2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32};
        vecs[2]  = '{2'b00, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, 32};
        vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 32};
        vecs[4]  = '{2'b01, 32'd5, 32'd10, 32'd5, 32'd0, 1'b0, 32};
        vecs[5]  = '{2'b01, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[6]  = '{2'b00, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 32};
`ifdef MULDIV_SIGNED_EN
        vecs[7]  = '{2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 32};
        vecs[8]  = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32};
        vecs[9]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32};
        vecs[10] = '{2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 32};
`else
        vecs[7]  = '{2'b10, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0, 32};
        vecs[8]  = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 32};
        vecs[9]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32};
        vecs[10] = '{2'b11, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd0, 1'b0, 32};
`endif
        vecs[11] = '{2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1};

        rst = 1'b1; start = 1'b0; op = 2'b00; dato_A = 32'd0; dato_B = 32'd0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Abort MULTU 6*7 with reset at E10; start held during reset must be dropped.
        op = 2'b00; dato_A = 32'd6; dato_B = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        rst = 1'b1; start = 1'b1;
        tick;
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) seen = 1'b1;
            tick;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);

        // Back-to-back: DIVU issued during the MULTU done cycle.
        op = 2'b00; dato_A = 32'd6; dato_B = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        chk("b2b_mul_lat", n, 32);
        chk("b2b_mul_done", {31'd0, done}, 32'd1);
        chk("b2b_mul_hi", hi, 32'd0);
        chk("b2b_mul_lo", lo, 32'd42);
        op = 2'b01; dato_A = 32'd42; dato_B = 32'd6; start = 1'b1;
        tick;
        start = 1'b0;
        chk("b2b_div_busy", {31'd0, busy}, 32'd1);
        chk("b2b_div_done_low", {31'd0, done}, 32'd0);
        chk("b2b_hold_lo", lo, 32'd42);
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        chk("b2b_div_lat", n, 32);
        chk("b2b_div_done", {31'd0, done}, 32'd1);
        chk("b2b_div_hi", hi, 32'd0);
        chk("b2b_div_lo", lo, 32'd7);
        tick;
        chk("b2b_done_fall", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
